ifm_buffer: RTL and testbench
=============================

IFM_BUFFER -- requirements
Module: ifm_buffer

Interface
REQ-001 The block SHALL expose parameter INPUT_WIDTH, default 32, as the bit width of each input word.
REQ-002 The block SHALL expose parameter OUTPUT_WIDTH, default 8, as the signed byte width of each window element.
REQ-003 The block SHALL expose parameter INPUT_REG, default 3, as the number of input words and window rows.
REQ-004 The block SHALL expose parameter PE_ARR_SIZE, default 9, as the number of window outputs (3x3, row-major).
REQ-005 The block SHALL expose parameter POOL_SIZE, default 4, as the number of active pooling elements (2x2).
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 layer_type  input  2  layer type: NONE=00, CONVOLUTION=01, POOLING=10, FULLY=11.
REQ-009 shift_mode  input  3  window update: RIGHT=001, DOWN=010, LEFT=100, NO_CHANGE=101, ALL=111.
REQ-010 ifm_read  input  1  capture ifm_input into the staging registers.
REQ-011 ifm_load  input  1  transfer staging data into the window per layer_type and shift_mode.
REQ-012 ifm_input  input  INPUT_REG x INPUT_WIDTH signed  row words; byte k is bits [8k+7:8k].
REQ-013 ifm_output  output  PE_ARR_SIZE x OUTPUT_WIDTH signed  registered window; element r*3+c is row r, column c.
REQ-014 counter_var  output  8  count of accepted loads.

Function
REQ-015 When ifm_read=1 at a clock edge, staging S[r] SHALL take ifm_input[r] for all r. The staged value is usable by a load at the next edge or later.
REQ-016 When ifm_load=1 at a clock edge, the window SHALL update from the staging value held before that edge. Simultaneous read and load SHALL therefore load the old staging and stage the new input.
REQ-017 CONVOLUTION loads SHALL update the window per shift_mode as follows.
- ALL: W[r][0..2] = S[r] bytes 2, 1, 0.
- RIGHT: W[r][0] = W[r][1], W[r][1] = W[r][2], W[r][2] = S[r] byte 0.
- LEFT: W[r][2] = W[r][1], W[r][1] = W[r][0], W[r][0] = S[r] byte 2.
- DOWN: W[0] = W[1], W[1] = W[2], W[2][0..2] = S[2] bytes 2, 1, 0.
- NO_CHANGE and the undefined codes 000, 011, 110: window held.
REQ-018 A POOLING load with ALL SHALL set W[r][0..1] = S[r] bytes 1, 0 for r=0,1. All other elements SHALL be zero.
REQ-019 A POOLING load with RIGHT or LEFT SHALL shift within the 2x2 region using byte 0 or byte 1 respectively. DOWN SHALL move row 1 to row 0 and take row 1 from S[1] bytes 1, 0. Elements outside the 2x2 region SHALL remain zero.
REQ-020 A FULLY load SHALL ignore shift_mode and set elements 0..3 = S[0] bytes 0..3 and elements 4..7 = S[1] bytes 0..3. Element 8 SHALL be S[2] byte 0.
REQ-021 When layer_type=NONE, loads SHALL be ignored; the window and counter_var are held.
REQ-022 counter_var SHALL increment by 1 on each ifm_load=1 edge with layer_type != NONE, wrapping from 255 to 0.
REQ-023 Bytes not selected by a mode SHALL be ignored; ifm_output SHALL be bit-sliced with no sign arithmetic.
REQ-024 With ifm_read=0 and ifm_load=0, all state SHALL be held.

Reset
REQ-025 While rst_n=0, staging, all ifm_output elements and counter_var SHALL be zero, regardless of clk.
REQ-026 Deassertion of rst_n during any activity SHALL resume from the all-zero state; no load is pending.

Configuration
REQ-027 With macro IFM_BUF_LOAD_CNT_EN defined, counter_var SHALL behave per REQ-022.
REQ-028 Without IFM_BUF_LOAD_CNT_EN, counter_var SHALL be a constant 0 and the counter register SHALL not be built.

Structure
REQ-029 Package ifm_buf_pkg SHALL hold the layer_type and shift_mode encodings and the default width and size constants.
REQ-030 One sub-module, ifm_row_shifter, SHALL implement the 3-byte row register with load, shift-left-in and shift-right-in operations. The block SHALL instantiate it once per row.

Verification
REQ-031 Reset, then check all outputs -> ifm_output all 0 and counter_var=0.
REQ-032 CONVOLUTION: stage 00010203, 00040506, 00070809, then load with ALL -> ifm_output = 1..9 and counter_var=1.
REQ-033 From REQ-032, stage 0A, 0B, 0C (byte 0), then load with RIGHT -> rows 02 03 0A / 05 06 0B / 08 09 0C and counter_var=2.
REQ-034 From REQ-033, stage S[2]=000D0E0F, then load with DOWN -> rows 05 06 0B / 08 09 0C / 0D 0E 0F.
REQ-035 From REQ-034, stage 000A0000 on all rows, then load with LEFT -> column 0 = 0A on every row, other columns shifted right. Next, a load with NO_CHANGE -> window held and counter_var incremented.
REQ-036 Assert rst_n=0 mid-sequence between clock edges -> outputs zero immediately. With layer_type=NONE, a load -> no change.

Source files
------------

// File: rtl/ifm_buf_pkg.sv
// Shared encodings and default geometry for the input feature-map window buffer.
package ifm_buf_pkg;

   localparam int IFM_INPUT_WIDTH  = 32;
   localparam int IFM_OUTPUT_WIDTH = 8;
   localparam int IFM_INPUT_REG    = 3;
   localparam int IFM_PE_ARR_SIZE  = 9;
   localparam int IFM_POOL_SIZE    = 4;

   typedef enum logic [1:0] {
      LAYER_NONE  = 2'b00,
      LAYER_CONV  = 2'b01,
      LAYER_POOL  = 2'b10,
      LAYER_FULLY = 2'b11
   } layer_t;

   typedef enum logic [2:0] {
      SHIFT_RIGHT     = 3'b001,
      SHIFT_DOWN      = 3'b010,
      SHIFT_LEFT      = 3'b100,
      SHIFT_NO_CHANGE = 3'b101,
      SHIFT_ALL       = 3'b111
   } shift_t;

   // Row register operations. SHL moves columns toward column 0 and inserts
   // at the last column; SHR moves columns away from column 0 and inserts at 0.
   typedef enum logic [1:0] {
      ROW_HOLD = 2'b00,
      ROW_LOAD = 2'b01,
      ROW_SHL  = 2'b10,
      ROW_SHR  = 2'b11
   } row_op_t;

   // Side length of a square pooling region holding n elements.
   function automatic int pool_dim(input int n);
      int d;
      d = 1;
      while (d * d < n) d++;
      return d;
   endfunction

endpackage

// File: rtl/ifm_row_shifter.sv
// One window row: a small byte register with parallel load and one-byte
// shift-in from either end. Column 0 sits at the least significant element.
module ifm_row_shifter
   import ifm_buf_pkg::*;
#(
   parameter int BYTE_W  = 8,
   parameter int ROW_LEN = 3
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  row_op_t                        i_op,
   input  logic [ROW_LEN-1:0][BYTE_W-1:0] i_load_data,
   input  logic [BYTE_W-1:0]              i_shift_in,
   output logic [ROW_LEN-1:0][BYTE_W-1:0] o_row
);

   logic [ROW_LEN-1:0][BYTE_W-1:0] r_row;

   // Row storage: load, shift toward column 0, shift away from column 0, or hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row <= '0;
      end else begin
         case (i_op)
            ROW_LOAD: r_row <= i_load_data;
            ROW_SHL:  r_row <= {i_shift_in, r_row[ROW_LEN-1:1]};
            ROW_SHR:  r_row <= {r_row[ROW_LEN-2:0], i_shift_in};
            default:  r_row <= r_row;
         endcase
      end
   end

   assign o_row = r_row;

endmodule

// File: rtl/ifm_buffer.sv
// Input feature-map window buffer: stages one word per row, then moves the
// staged bytes into a registered 3x3 window according to layer type and shift
// mode. Optional load counter is built only when IFM_BUF_LOAD_CNT_EN is defined.
module ifm_buffer
   import ifm_buf_pkg::*;
#(
   parameter int INPUT_WIDTH  = IFM_INPUT_WIDTH,
   parameter int OUTPUT_WIDTH = IFM_OUTPUT_WIDTH,
   parameter int INPUT_REG    = IFM_INPUT_REG,
   parameter int PE_ARR_SIZE  = IFM_PE_ARR_SIZE,
   parameter int POOL_SIZE    = IFM_POOL_SIZE
)(
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [1:0]                                    layer_type,
   input  logic [2:0]                                    shift_mode,
   input  logic                                          ifm_read,
   input  logic                                          ifm_load,
   input  logic signed [INPUT_REG-1:0][INPUT_WIDTH-1:0]  ifm_input,
   output logic signed [PE_ARR_SIZE-1:0][OUTPUT_WIDTH-1:0] ifm_output,
   output logic [7:0]                                    counter_var
);

   localparam int ROW_LEN    = PE_ARR_SIZE / INPUT_REG;
   localparam int WORD_BYTES = INPUT_WIDTH / OUTPUT_WIDTH;
   localparam int POOL_DIM   = pool_dim(POOL_SIZE);

   logic [INPUT_REG-1:0][INPUT_WIDTH-1:0]                  r_stage;
   logic [INPUT_REG-1:0][WORD_BYTES-1:0][OUTPUT_WIDTH-1:0] w_sbyte;
   logic [INPUT_REG-1:0][ROW_LEN-1:0][OUTPUT_WIDTH-1:0]    w_win;
   logic [INPUT_REG-1:0][ROW_LEN-1:0][OUTPUT_WIDTH-1:0]    w_next_row;
   logic [INPUT_REG-1:0][ROW_LEN-1:0][OUTPUT_WIDTH-1:0]    w_fully_row;
   logic                                                   w_unused_bits;

   // Staging words; a load always consumes the value held before its edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage <= '0;
      end else if (ifm_read) begin
         r_stage <= ifm_input;
      end
   end

   // The top byte of the last staged word is never selected by any mode.
   assign w_unused_bits = ^w_sbyte[INPUT_REG-1][WORD_BYTES-1];

   genvar gi, gc;
   generate
      for (gi = 0; gi < INPUT_REG; gi++) begin : g_row
         row_op_t                             w_row_op;
         logic [ROW_LEN-1:0][OUTPUT_WIDTH-1:0] w_row_data;
         logic [OUTPUT_WIDTH-1:0]              w_row_in;

         assign w_sbyte[gi] = r_stage[gi];

         // DOWN source: the row below, or fresh staged bytes for the bottom row.
         if (gi < INPUT_REG - 1) begin : g_mid
            assign w_next_row[gi] = w_win[gi+1];
         end else begin : g_bottom
            for (gc = 0; gc < ROW_LEN; gc++) begin : g_col
               assign w_next_row[gi][gc] = w_sbyte[gi][ROW_LEN-1-gc];
            end
         end

         // FULLY packs staged bytes in order across the flattened window.
         for (gc = 0; gc < ROW_LEN; gc++) begin : g_fully
            localparam int E = gi * ROW_LEN + gc;
            assign w_fully_row[gi][gc] = w_sbyte[E / WORD_BYTES][E % WORD_BYTES];
         end

         // Per-row operation select from layer type and shift mode.
         always_comb begin
            w_row_op   = ROW_HOLD;
            w_row_data = '0;
            w_row_in   = '0;
            if (ifm_load) begin
               case (layer_type)
                  LAYER_CONV: begin
                     case (shift_mode)
                        SHIFT_ALL: begin
                           w_row_op = ROW_LOAD;
                           for (int c = 0; c < ROW_LEN; c++)
                              w_row_data[c] = w_sbyte[gi][ROW_LEN-1-c];
                        end
                        SHIFT_RIGHT: begin
                           w_row_op = ROW_SHL;
                           w_row_in = w_sbyte[gi][0];
                        end
                        SHIFT_LEFT: begin
                           w_row_op = ROW_SHR;
                           w_row_in = w_sbyte[gi][ROW_LEN-1];
                        end
                        SHIFT_DOWN: begin
                           w_row_op   = ROW_LOAD;
                           w_row_data = w_next_row[gi];
                        end
                        default: ;
                     endcase
                  end
                  LAYER_POOL: begin
                     // Any real pooling move rewrites the whole row so that
                     // everything outside the 2x2 region is forced to zero.
                     if (shift_mode == SHIFT_ALL || shift_mode == SHIFT_RIGHT ||
                         shift_mode == SHIFT_LEFT || shift_mode == SHIFT_DOWN) begin
                        w_row_op = ROW_LOAD;
                        if (gi < POOL_DIM) begin
                           case (shift_mode)
                              SHIFT_ALL: begin
                                 w_row_data[0] = w_sbyte[gi][1];
                                 w_row_data[1] = w_sbyte[gi][0];
                              end
                              SHIFT_RIGHT: begin
                                 w_row_data[0] = w_win[gi][1];
                                 w_row_data[1] = w_sbyte[gi][0];
                              end
                              SHIFT_LEFT: begin
                                 w_row_data[0] = w_sbyte[gi][1];
                                 w_row_data[1] = w_win[gi][0];
                              end
                              default: begin
                                 if (gi < POOL_DIM - 1) begin
                                    w_row_data[0] = w_next_row[gi][0];
                                    w_row_data[1] = w_next_row[gi][1];
                                 end else begin
                                    w_row_data[0] = w_sbyte[gi][1];
                                    w_row_data[1] = w_sbyte[gi][0];
                                 end
                              end
                           endcase
                        end
                     end
                  end
                  LAYER_FULLY: begin
                     w_row_op   = ROW_LOAD;
                     w_row_data = w_fully_row[gi];
                  end
                  default: ;
               endcase
            end
         end

         ifm_row_shifter #(
            .BYTE_W  (OUTPUT_WIDTH),
            .ROW_LEN (ROW_LEN)
         ) u_row (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_op        (w_row_op),
            .i_load_data (w_row_data),
            .i_shift_in  (w_row_in),
            .o_row       (w_win[gi])
         );

         assign ifm_output[gi*ROW_LEN +: ROW_LEN] = w_win[gi];
      end
   endgenerate

`ifdef IFM_BUF_LOAD_CNT_EN
   logic       w_load_accept;
   logic [7:0] r_load_cnt;

   assign w_load_accept = ifm_load && (layer_type != LAYER_NONE);

   // Count accepted loads, wrapping naturally at 8 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_load_cnt <= '0;
      end else if (w_load_accept) begin
         r_load_cnt <= r_load_cnt + 8'd1;
      end
   end

   assign counter_var = r_load_cnt;
`else
   assign counter_var = 8'd0;
`endif

endmodule

// File: tb/tb_ifm_buffer.sv
// Self-checking bench for ifm_buffer: directed scenarios plus randomized
// traffic checked against a byte-level window model.
module tb_ifm_buffer;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [1:0]              layer_type;
   logic [2:0]              shift_mode;
   logic                    ifm_read;
   logic                    ifm_load;
   logic signed [2:0][31:0] ifm_input;
   logic signed [8:0][7:0]  ifm_output;
   logic [7:0]              counter_var;

   int n_cmp = 0;
   int n_bad = 0;
   int n_txn = 0;

   // Reference state: staged words, 3x3 byte window, load count.
   logic [31:0] m_stage [3];
   logic [7:0]  m_win   [3][3];
   logic [7:0]  m_cnt;

   ifm_buffer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .layer_type  (layer_type),
      .shift_mode  (shift_mode),
      .ifm_read    (ifm_read),
      .ifm_load    (ifm_load),
      .ifm_input   (ifm_input),
      .ifm_output  (ifm_output),
      .counter_var (counter_var)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] sb(input logic [31:0] w, input int k);
      return w[8*k +: 8];
   endfunction

   function automatic void model_reset();
      m_cnt = 8'd0;
      for (int r = 0; r < 3; r++) begin
         m_stage[r] = 32'd0;
         for (int c = 0; c < 3; c++) m_win[r][c] = 8'd0;
      end
   endfunction

   function automatic void model_load(input logic [1:0] lt, input logic [2:0] sm);
      logic [7:0] o [3][3];
      o = m_win;
      if (lt == 2'b00) return;
      m_cnt = m_cnt + 8'd1;
      case (lt)
         2'b01: begin
            case (sm)
               3'b111: for (int r = 0; r < 3; r++)
                          for (int c = 0; c < 3; c++) m_win[r][c] = sb(m_stage[r], 2 - c);
               3'b001: for (int r = 0; r < 3; r++) begin
                          m_win[r][0] = o[r][1]; m_win[r][1] = o[r][2]; m_win[r][2] = sb(m_stage[r], 0);
                       end
               3'b100: for (int r = 0; r < 3; r++) begin
                          m_win[r][0] = sb(m_stage[r], 2); m_win[r][1] = o[r][0]; m_win[r][2] = o[r][1];
                       end
               3'b010: for (int c = 0; c < 3; c++) begin
                          m_win[0][c] = o[1][c]; m_win[1][c] = o[2][c]; m_win[2][c] = sb(m_stage[2], 2 - c);
                       end
               default: ;
            endcase
         end
         2'b10: begin
            if (sm == 3'b111 || sm == 3'b001 || sm == 3'b100 || sm == 3'b010) begin
               for (int r = 0; r < 3; r++)
                  for (int c = 0; c < 3; c++) m_win[r][c] = 8'd0;
               for (int r = 0; r < 2; r++) begin
                  case (sm)
                     3'b111: begin m_win[r][0] = sb(m_stage[r], 1); m_win[r][1] = sb(m_stage[r], 0); end
                     3'b001: begin m_win[r][0] = o[r][1];           m_win[r][1] = sb(m_stage[r], 0); end
                     3'b100: begin m_win[r][0] = sb(m_stage[r], 1); m_win[r][1] = o[r][0];           end
                     default: begin
                        if (r == 0) begin m_win[0][0] = o[1][0]; m_win[0][1] = o[1][1]; end
                        else begin m_win[1][0] = sb(m_stage[1], 1); m_win[1][1] = sb(m_stage[1], 0); end
                     end
                  endcase
               end
            end
         end
         default: begin
            for (int e = 0; e < 9; e++)
               m_win[e/3][e%3] = (e < 4) ? sb(m_stage[0], e) :
                                 (e < 8) ? sb(m_stage[1], e - 4) : sb(m_stage[2], 0);
         end
      endcase
   endfunction

   function automatic logic [71:0] exp_out();
      logic [71:0] v;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) v[(r*3+c)*8 +: 8] = m_win[r][c];
      return v;
   endfunction

   function automatic logic [7:0] exp_cnt();
`ifdef IFM_BUF_LOAD_CNT_EN
      return m_cnt;
`else
      return 8'd0;
`endif
   endfunction

   // One clocked transaction; the model sees the load before the new staging.
   task automatic do_cycle(input logic rd, input logic ld, input logic [1:0] lt,
                           input logic [2:0] sm, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2);
      ifm_read = rd; ifm_load = ld; layer_type = lt; shift_mode = sm;
      ifm_input[0] = w0; ifm_input[1] = w1; ifm_input[2] = w2;
      @(posedge clk);
      if (ld) model_load(lt, sm);
      if (rd) begin m_stage[0] = w0; m_stage[1] = w1; m_stage[2] = w2; end
      #1;
      ifm_read = 1'b0; ifm_load = 1'b0;
      n_txn++;
      $display("txn %0d rd=%0b ld=%0b lt=%0d sm=%03b in=%h/%h/%h out=%h cnt=%0d",
               n_txn, rd, ld, lt, sm, w0, w1, w2, ifm_output, counter_var);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ifm_read = 1'b1; ifm_load = 1'b1; layer_type = 2'b01;
      shift_mode = 3'b111; ifm_input = {32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D};
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (ifm_output !== 72'd0) begin n_bad++; $display("FAIL reset_out got=%h want=0", ifm_output); end
      n_cmp++; if (counter_var !== 8'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d want=0", counter_var); end
      ifm_read = 1'b0; ifm_load = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (ifm_output !== 72'd0) begin n_bad++; $display("FAIL reset_release got=%h want=0", ifm_output); end
   endtask

   task automatic test_conv_directed();
      do_cycle(1, 0, 2'b01, 3'b111, 32'h00010203, 32'h00040506, 32'h00070809);
      do_cycle(0, 1, 2'b01, 3'b111, 32'h0, 32'h0, 32'h0);
      n_cmp++; if (ifm_output !== 72'h09_08_07_06_05_04_03_02_01) begin n_bad++; $display("FAIL conv_all got=%h want=%h", ifm_output, 72'h09_08_07_06_05_04_03_02_01); end
      n_cmp++; if (counter_var !== exp_cnt()) begin n_bad++; $display("FAIL conv_all_cnt got=%0d want=%0d", counter_var, exp_cnt()); end
      do_cycle(1, 0, 2'b01, 3'b111, 32'h0000000A, 32'h0000000B, 32'h0000000C);
      do_cycle(0, 1, 2'b01, 3'b001, 32'h0, 32'h0, 32'h0);
      n_cmp++; if (ifm_output !== 72'h0C_09_08_0B_06_05_0A_03_02) begin n_bad++; $display("FAIL conv_right got=%h want=%h", ifm_output, 72'h0C_09_08_0B_06_05_0A_03_02); end
      n_cmp++; if (counter_var !== exp_cnt()) begin n_bad++; $display("FAIL conv_right_cnt got=%0d want=%0d", counter_var, exp_cnt()); end
      do_cycle(1, 0, 2'b01, 3'b111, 32'h0, 32'h0, 32'h000D0E0F);
      do_cycle(0, 1, 2'b01, 3'b010, 32'h0, 32'h0, 32'h0);
      n_cmp++; if (ifm_output !== 72'h0F_0E_0D_0C_09_08_0B_06_05) begin n_bad++; $display("FAIL conv_down got=%h want=%h", ifm_output, 72'h0F_0E_0D_0C_09_08_0B_06_05); end
      do_cycle(1, 0, 2'b01, 3'b111, 32'h000A0000, 32'h000A0000, 32'h000A0000);
      do_cycle(0, 1, 2'b01, 3'b100, 32'h0, 32'h0, 32'h0);
      n_cmp++; if (ifm_output !== 72'h0E_0D_0A_09_08_0A_06_05_0A) begin n_bad++; $display("FAIL conv_left got=%h want=%h", ifm_output, 72'h0E_0D_0A_09_08_0A_06_05_0A); end
      do_cycle(0, 1, 2'b01, 3'b101, 32'h0, 32'h0, 32'h0);
      n_cmp++; if (ifm_output !== 72'h0E_0D_0A_09_08_0A_06_05_0A) begin n_bad++; $display("FAIL conv_hold got=%h want=%h", ifm_output, 72'h0E_0D_0A_09_08_0A_06_05_0A); end
      n_cmp++; if (counter_var !== exp_cnt()) begin n_bad++; $display("FAIL conv_hold_cnt got=%0d want=%0d", counter_var, exp_cnt()); end
      n_cmp++; if (ifm_output !== exp_out()) begin n_bad++; $display("FAIL conv_model got=%h want=%h", ifm_output, exp_out()); end
   endtask

   task automatic test_async_reset();
      do_cycle(1, 1, 2'b11, 3'b000, $urandom | 32'h1, $urandom, $urandom);
      do_cycle(0, 1, 2'b11, 3'b000, 32'h0, 32'h0, 32'h0);
      #3 rst_n = 1'b0;
      #1;
      n_cmp++; if (ifm_output !== 72'd0) begin n_bad++; $display("FAIL async_rst_out got=%h want=0", ifm_output); end
      n_cmp++; if (counter_var !== 8'd0) begin n_bad++; $display("FAIL async_rst_cnt got=%0d want=0", counter_var); end
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      do_cycle(0, 1, 2'b11, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
      n_cmp++; if (ifm_output !== 72'd0) begin n_bad++; $display("FAIL async_rst_stage got=%h want=0", ifm_output); end
      n_cmp++; if (counter_var !== exp_cnt()) begin n_bad++; $display("FAIL async_rst_cnt2 got=%0d want=%0d", counter_var, exp_cnt()); end
   endtask

   task automatic test_none();
      do_cycle(1, 0, 2'b00, 3'b111, $urandom, $urandom, $urandom);
      do_cycle(1, 1, 2'b11, 3'b111, $urandom, $urandom, $urandom);
      do_cycle(0, 1, 2'b00, 3'b111, 32'h0, 32'h0, 32'h0);
      n_cmp++; if (ifm_output !== exp_out()) begin n_bad++; $display("FAIL none_out got=%h want=%h", ifm_output, exp_out()); end
      n_cmp++; if (counter_var !== exp_cnt()) begin n_bad++; $display("FAIL none_cnt got=%0d want=%0d", counter_var, exp_cnt()); end
   endtask

   task automatic test_pool();
      logic [2:0] seq [6] = '{3'b111, 3'b001, 3'b100, 3'b010, 3'b101, 3'b001};
      for (int i = 0; i < 6; i++) begin
         do_cycle(1, 0, 2'b10, 3'b111, $urandom, $urandom, $urandom);
         do_cycle(0, 1, 2'b10, seq[i], 32'h0, 32'h0, 32'h0);
         n_cmp++; if (ifm_output !== exp_out()) begin n_bad++; $display("FAIL pool_%03b got=%h want=%h", seq[i], ifm_output, exp_out()); end
      end
   endtask

   task automatic test_fully();
      for (int i = 0; i < 3; i++) begin
         do_cycle(1, 0, 2'b11, 3'b000, $urandom, $urandom, $urandom);
         do_cycle(0, 1, 2'b11, 3'($urandom_range(0, 7)), 32'h0, 32'h0, 32'h0);
         n_cmp++; if (ifm_output !== exp_out()) begin n_bad++; $display("FAIL fully got=%h want=%h", ifm_output, exp_out()); end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++) begin
         do_cycle(1, 1, 2'($urandom_range(1, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
         n_cmp++; if (ifm_output !== exp_out()) begin n_bad++; $display("FAIL b2b_out i=%0d got=%h want=%h", i, ifm_output, exp_out()); end
         n_cmp++; if (counter_var !== exp_cnt()) begin n_bad++; $display("FAIL b2b_cnt i=%0d got=%0d want=%0d", i, counter_var, exp_cnt()); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 150; i++) begin
         do_cycle(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
         n_cmp++; if (ifm_output !== exp_out()) begin n_bad++; $display("FAIL rand_out i=%0d got=%h want=%h", i, ifm_output, exp_out()); end
         n_cmp++; if (counter_var !== exp_cnt()) begin n_bad++; $display("FAIL rand_cnt i=%0d got=%0d want=%0d", i, counter_var, exp_cnt()); end
      end
   endtask

   task automatic test_counter_wrap();
      for (int i = 0; i < 260; i++)
         do_cycle(1'($urandom), 1, 2'($urandom_range(1, 3)), 3'($urandom), $urandom, $urandom, $urandom);
      n_cmp++; if (counter_var !== exp_cnt()) begin n_bad++; $display("FAIL wrap_cnt got=%0d want=%0d", counter_var, exp_cnt()); end
      n_cmp++; if (ifm_output !== exp_out()) begin n_bad++; $display("FAIL wrap_out got=%h want=%h", ifm_output, exp_out()); end
   endtask

   initial begin
      test_reset();
      test_conv_directed();
      test_async_reset();
      test_none();
      test_pool();
      test_fully();
      test_back_to_back();
      test_random();
      test_counter_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
